exe_stage: RTL and testbench

//  Execute stage between decode (ID) and the memory stage (MEM). Latches the ID->EXE bus, computes the result

---
 rtl/exe_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_exe_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// Execute stage: latches the ID->EXE bus, computes via the single-cycle alu or an iterative divider,
// issues the data-SRAM request and packs the EXE->MEM bus plus hazard/forwarding info for decode.
`timescale 1ns/1ps

module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] alu_src1,
    input  logic [31:0] alu_src2,
    output logic [31:0] alu_result
);
    logic        op_add, op_sub, op_slt, op_sltu, op_and, op_nor;
    logic        op_or, op_xor, op_sll, op_srl, op_sra, op_lui;
    logic [31:0] adder_b;
    logic        adder_cin;
    logic [32:0] adder_sum;
    logic        slt_result;
    logic        sltu_result;
    logic [31:0] sll_result;
    logic [31:0] srl_result;
    logic [31:0] sra_result;

    assign {op_lui, op_sra, op_srl, op_sll, op_xor, op_or,
            op_nor, op_and, op_sltu, op_slt, op_sub, op_add} = alu_op;

    // Subtract and both compares share the adder as src1 + ~src2 + 1.
    assign adder_b   = (op_sub | op_slt | op_sltu) ? ~alu_src2 : alu_src2;
    assign adder_cin = op_sub | op_slt | op_sltu;
    assign adder_sum = {1'b0, alu_src1} + {1'b0, adder_b} + {32'd0, adder_cin};

    assign slt_result  = (alu_src1[31] & ~alu_src2[31])
                       | (~(alu_src1[31] ^ alu_src2[31]) & adder_sum[31]);
    assign sltu_result = ~adder_sum[32];

    assign sll_result = alu_src1 << alu_src2[4:0];
    assign srl_result = alu_src1 >> alu_src2[4:0];
    assign sra_result = $signed(alu_src1) >>> alu_src2[4:0];

    assign alu_result = ({32{op_add | op_sub}} & adder_sum[31:0])
                      | ({32{op_slt}}          & {31'd0, slt_result})
                      | ({32{op_sltu}}         & {31'd0, sltu_result})
                      | ({32{op_and}}          & (alu_src1 & alu_src2))
                      | ({32{op_nor}}          & ~(alu_src1 | alu_src2))
                      | ({32{op_or}}           & (alu_src1 | alu_src2))
                      | ({32{op_xor}}          & (alu_src1 ^ alu_src2))
                      | ({32{op_sll}}          & sll_result)
                      | ({32{op_srl}}          & srl_result)
                      | ({32{op_sra}}          & sra_result)
                      | ({32{op_lui}}          & alu_src2);
endmodule

module exe_stage #(
    parameter int DS_TO_ES_BUS_WD = 153,
    parameter int ES_TO_MS_BUS_WD = 73
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_allowin,
    input  logic                       ms_allowin,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_we,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata,
    output logic                       gr_we_exe,
    output logic [4:0]                 dest_exe,
    output logic                       exe_fwd_ok,
    output logic                       exe_load_op,
    output logic [31:0]                forward_data_exe
);
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    logic                       es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus_r;
    logic                       es_ready_go;
    logic                       es_handoff;

    logic [2:0]  div_op;
    logic [11:0] alu_op;
    logic        load_op;
    logic        mem_we;
    logic        inst_ld_w;
    logic        inst_lu12i_w;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rkd_value;
    logic [31:0] pc;

    logic        div_en;
    logic        div_signed;
    logic        div_rem;
    logic [31:0] alu_result;
    logic [31:0] es_result;

    div_state_t  div_state, div_state_n;
    logic [4:0]  div_cnt, div_cnt_n;
    logic [31:0] dvd_sh, dvd_sh_n;
    logic [31:0] dvs, dvs_n;
    logic [31:0] rem_acc, rem_acc_n;
    logic [31:0] quo, quo_n;
    logic        q_neg, q_neg_n;
    logic        r_neg, r_neg_n;

    logic [31:0] src1_mag;
    logic [31:0] src2_mag;
    logic [33:0] trial;
    logic [31:0] step_rem;
    logic [31:0] step_quo;

    assign {div_op, alu_op, load_op, mem_we, inst_ld_w, inst_lu12i_w,
            gr_we, dest, src1, src2, rkd_value, pc} = ds_to_es_bus_r;

    assign div_en     = div_op[2];
    assign div_signed = div_op[1];
    assign div_rem    = div_op[0];

    assign es_ready_go    = !div_en | (div_state == DIV_DONE);
    assign es_allowin     = !es_valid | (es_ready_go & ms_allowin);
    assign es_to_ms_valid = es_valid & es_ready_go;
    assign es_handoff     = es_valid & es_ready_go & ms_allowin;

    // Valid bit and bus register; the bus only captures real instructions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid       <= 1'b0;
            ds_to_es_bus_r <= '0;
        end else begin
            if (es_allowin) begin
                es_valid <= ds_to_es_valid;
            end
            if (ds_to_es_valid & es_allowin) begin
                ds_to_es_bus_r <= ds_to_es_bus;
            end
        end
    end

    alu u_alu (
        .alu_op     (alu_op),
        .alu_src1   (src1),
        .alu_src2   (src2),
        .alu_result (alu_result)
    );

    assign src1_mag = (div_signed & src1[31]) ? (32'd0 - src1) : src1;
    assign src2_mag = (div_signed & src2[31]) ? (32'd0 - src2) : src2;

    // Restoring step: shift in the next dividend bit, subtract if the divisor fits.
    assign trial    = {1'b0, rem_acc, dvd_sh[31]} - {2'b00, dvs};
    assign step_rem = trial[33] ? {rem_acc[30:0], dvd_sh[31]} : trial[31:0];
    assign step_quo = {quo[30:0], ~trial[33]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= 5'd0;
            dvd_sh    <= 32'd0;
            dvs       <= 32'd0;
            rem_acc   <= 32'd0;
            quo       <= 32'd0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            div_state <= div_state_n;
            div_cnt   <= div_cnt_n;
            dvd_sh    <= dvd_sh_n;
            dvs       <= dvs_n;
            rem_acc   <= rem_acc_n;
            quo       <= quo_n;
            q_neg     <= q_neg_n;
            r_neg     <= r_neg_n;
        end
    end

    // Divider next-state; DONE holds quotient/remainder already sign-corrected.
    always_comb begin
        div_state_n = div_state;
        div_cnt_n   = div_cnt;
        dvd_sh_n    = dvd_sh;
        dvs_n       = dvs;
        rem_acc_n   = rem_acc;
        quo_n       = quo;
        q_neg_n     = q_neg;
        r_neg_n     = r_neg;
        case (div_state)
            DIV_IDLE: begin
                if (es_valid & div_en) begin
                    if (src2 == 32'd0) begin
                        div_state_n = DIV_DONE;
                        quo_n       = 32'hFFFF_FFFF;
                        rem_acc_n   = src1;
                    end else begin
                        div_state_n = DIV_BUSY;
                        div_cnt_n   = 5'd0;
                        dvd_sh_n    = src1_mag;
                        dvs_n       = src2_mag;
                        rem_acc_n   = 32'd0;
                        quo_n       = 32'd0;
                        q_neg_n     = div_signed & (src1[31] ^ src2[31]);
                        r_neg_n     = div_signed & src1[31];
                    end
                end
            end
            DIV_BUSY: begin
                div_cnt_n = div_cnt + 5'd1;
                dvd_sh_n  = {dvd_sh[30:0], 1'b0};
                rem_acc_n = step_rem;
                quo_n     = step_quo;
                if (div_cnt == 5'd31) begin
                    div_state_n = DIV_DONE;
                    quo_n       = q_neg ? (32'd0 - step_quo) : step_quo;
                    rem_acc_n   = r_neg ? (32'd0 - step_rem) : step_rem;
                end
            end
            DIV_DONE: begin
                if (es_handoff) begin
                    div_state_n = DIV_IDLE;
                end
            end
            default: begin
                div_state_n = DIV_IDLE;
            end
        endcase
    end

    assign es_result = div_en ? (div_rem ? rem_acc : quo) : alu_result;

    assign es_to_ms_bus = {inst_ld_w, inst_lu12i_w, load_op, gr_we, dest, es_result, pc};

    // The SRAM strobe is tied to the handoff so a stalled access never repeats.
    assign data_sram_en    = es_handoff & (load_op | mem_we);
    assign data_sram_we    = {4{data_sram_en & mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

    assign gr_we_exe        = es_valid & gr_we;
    assign dest_exe         = es_valid ? dest : 5'd0;
    assign exe_fwd_ok       = es_valid & !load_op & (!div_en | (div_state == DIV_DONE));
    assign exe_load_op      = es_valid & load_op;
    assign forward_data_exe = es_valid ? es_result : 32'd0;
endmodule

// File: tb/tb_exe_stage.sv
// Directed and randomized bench for exe_stage; expected results come from plain-arithmetic
// models of the alu ops and of truncating signed/unsigned division.
`timescale 1ns/1ps

module tb_exe_stage;
    logic         clk;
    logic         reset;
    logic         ds_to_es_valid;
    logic [152:0] ds_to_es_bus;
    logic         es_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [72:0]  es_to_ms_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;
    logic         gr_we_exe;
    logic [4:0]   dest_exe;
    logic         exe_fwd_ok;
    logic         exe_load_op;
    logic [31:0]  forward_data_exe;

    int checks = 0;
    int errors = 0;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [2:0]  DIV_S  = 3'b110;
    localparam logic [2:0]  MOD_S  = 3'b111;
    localparam logic [2:0]  DIV_U  = 3'b100;
    localparam logic [2:0]  MOD_U  = 3'b101;

    exe_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ds_to_es_valid   (ds_to_es_valid),
        .ds_to_es_bus     (ds_to_es_bus),
        .es_allowin       (es_allowin),
        .ms_allowin       (ms_allowin),
        .es_to_ms_valid   (es_to_ms_valid),
        .es_to_ms_bus     (es_to_ms_bus),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata),
        .gr_we_exe        (gr_we_exe),
        .dest_exe         (dest_exe),
        .exe_fwd_ok       (exe_fwd_ok),
        .exe_load_op      (exe_load_op),
        .forward_data_exe (forward_data_exe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [152:0] mkBus(input logic [2:0] div_op, input logic [11:0] alu_op,
                                           input logic load_op, input logic mem_we,
                                           input logic [4:0] dest, input logic [31:0] src1,
                                           input logic [31:0] src2, input logic [31:0] rkd,
                                           input logic [31:0] pc);
        return {div_op, alu_op, load_op, mem_we, 1'b0, 1'b0, 1'b1, dest, src1, src2, rkd, pc};
    endfunction

    // Reference: architectural meaning of each op, independent of how the hardware gets there.
    function automatic logic [31:0] refModel(input logic [2:0] div_op, input logic [11:0] alu_op,
                                             input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [31:0] res;
        res = 32'd0;
        if (div_op[2]) begin
            if (b == 32'd0) begin
                res = div_op[0] ? a : 32'hFFFF_FFFF;
            end else if (div_op[1]) begin
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                res = div_op[0] ? r[31:0] : q[31:0];
            end else begin
                res = div_op[0] ? (a % b) : (a / b);
            end
        end else begin
            case (alu_op)
                12'h001: res = a + b;
                12'h002: res = a - b;
                12'h004: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                12'h008: res = (a < b) ? 32'd1 : 32'd0;
                12'h010: res = a & b;
                12'h020: res = ~(a | b);
                12'h040: res = a | b;
                12'h080: res = a ^ b;
                12'h100: res = a << b[4:0];
                12'h200: res = a >> b[4:0];
                12'h400: res = $signed(a) >>> b[4:0];
                12'h800: res = b;
                default: res = 32'd0;
            endcase
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [152:0] bus);
        ds_to_es_valid = 1'b1;
        ds_to_es_bus   = bus;
        tick();
        ds_to_es_valid = 1'b0;
    endtask

    // Issue one instruction with MEM always ready, measure cycles until it is offered, check result.
    task automatic runInstr(input string tag, input logic [152:0] bus, input int exp_lat,
                            input logic [31:0] exp_res);
        int lat;
        int allowin_seen;
        lat = 0;
        allowin_seen = 0;
        applyStimulus(bus);
        while (!es_to_ms_valid && lat < 100) begin
            if (es_allowin) allowin_seen++;
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " result"}, es_to_ms_bus[63:32], exp_res);
        if (exp_lat > 0) checkOutput({tag, " allowin while busy"}, 32'(allowin_seen), 32'd0);
        tick();
    endtask

    initial begin
        logic [2:0]  dop;
        logic [11:0] aop;
        logic [31:0] s1, s2;
        int          lat;

        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        #12;
        checkOutput("reset es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        checkOutput("reset es_allowin", 32'(es_allowin), 32'd1);
        checkOutput("reset sram_en", 32'(data_sram_en), 32'd0);
        checkOutput("reset fwd_ok", 32'(exe_fwd_ok), 32'd0);
        checkOutput("reset load_op", 32'(exe_load_op), 32'd0);
        checkOutput("reset fwd_data", forward_data_exe, 32'd0);
        checkOutput("reset gr_we_exe", 32'(gr_we_exe), 32'd0);
        tick();
        reset = 1'b0;

        // Add: offered the very next cycle, forwarding final.
        applyStimulus(mkBus(3'b000, OP_ADD, 1'b0, 1'b0, 5'd3, 32'd5, 32'd7, 32'd0, 32'h1C00_0000));
        checkOutput("add valid", 32'(es_to_ms_valid), 32'd1);
        checkOutput("add result", es_to_ms_bus[63:32], 32'd12);
        checkOutput("add pc", es_to_ms_bus[31:0], 32'h1C00_0000);
        checkOutput("add allowin", 32'(es_allowin), 32'd1);
        checkOutput("add fwd_ok", 32'(exe_fwd_ok), 32'd1);
        checkOutput("add fwd_data", forward_data_exe, 32'd12);
        checkOutput("add dest_exe", 32'(dest_exe), 32'd3);
        tick();
        checkOutput("add drained", 32'(es_to_ms_valid), 32'd0);

        runInstr("div -7/2", mkBus(DIV_S, 12'd0, 1'b0, 1'b0, 5'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0),
                 33, 32'hFFFF_FFFD);
        runInstr("mod -7/2", mkBus(MOD_S, 12'd0, 1'b0, 1'b0, 5'd4, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0),
                 33, 32'hFFFF_FFFF);
        runInstr("divu by 0", mkBus(DIV_U, 12'd0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0, 32'd0, 32'd0),
                 1, 32'hFFFF_FFFF);
        runInstr("modu by 0", mkBus(MOD_U, 12'd0, 1'b0, 1'b0, 5'd5, 32'h1234, 32'd0, 32'd0, 32'd0),
                 1, 32'h1234);
        runInstr("div overflow", mkBus(DIV_S, 12'd0, 1'b0, 1'b0, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0),
                 33, 32'h8000_0000);
        runInstr("mod overflow", mkBus(MOD_S, 12'd0, 1'b0, 1'b0, 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0),
                 33, 32'd0);

        // Store held by MEM for three cycles: one strobe only, on release.
        ms_allowin = 1'b0;
        applyStimulus(mkBus(3'b000, OP_ADD, 1'b0, 1'b1, 5'd0, 32'h1000, 32'd0, 32'hA5A5_A5A5, 32'd0));
        for (int i = 0; i < 3; i++) begin
            checkOutput("store stalled en", 32'(data_sram_en), 32'd0);
            checkOutput("store stalled allowin", 32'(es_allowin), 32'd0);
            tick();
        end
        ms_allowin = 1'b1;
        #1;
        checkOutput("store en", 32'(data_sram_en), 32'd1);
        checkOutput("store we", 32'(data_sram_we), 32'hF);
        checkOutput("store addr", data_sram_addr, 32'h1000);
        checkOutput("store wdata", data_sram_wdata, 32'hA5A5_A5A5);
        tick();
        checkOutput("store en after", 32'(data_sram_en), 32'd0);

        // Load sits in EXE: decode must see load-use, no final forward.
        ms_allowin = 1'b0;
        applyStimulus(mkBus(3'b000, OP_ADD, 1'b1, 1'b0, 5'd9, 32'h2000, 32'h4, 32'd0, 32'd0));
        checkOutput("load exe_load_op", 32'(exe_load_op), 32'd1);
        checkOutput("load fwd_ok", 32'(exe_fwd_ok), 32'd0);
        checkOutput("load en stalled", 32'(data_sram_en), 32'd0);
        ms_allowin = 1'b1;
        #1;
        checkOutput("load en", 32'(data_sram_en), 32'd1);
        checkOutput("load we", 32'(data_sram_we), 32'h0);
        tick();

        // Reset ten cycles into a divide discards it; the next divide takes full latency.
        applyStimulus(mkBus(DIV_U, 12'd0, 1'b0, 1'b0, 5'd7, 32'd1000, 32'd3, 32'd0, 32'd0));
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        checkOutput("midreset valid", 32'(es_to_ms_valid), 32'd0);
        checkOutput("midreset allowin", 32'(es_allowin), 32'd1);
        checkOutput("midreset gr_we", 32'(gr_we_exe), 32'd0);
        tick();
        reset = 1'b0;
        runInstr("div after reset", mkBus(DIV_U, 12'd0, 1'b0, 1'b0, 5'd7, 32'd1000, 32'd3, 32'd0, 32'd0),
                 33, 32'd333);

        // Randomized mix of alu ops and divides, including zero and overflow operands.
        for (int n = 0; n < 40; n++) begin
            s1 = $urandom;
            s2 = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                dop = {1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))};
                aop = 12'd0;
                case ($urandom_range(0, 5))
                    0: s2 = 32'd0;
                    1: begin s1 = 32'h8000_0000; s2 = 32'hFFFF_FFFF; end
                    2: s2 = 32'($urandom_range(1, 15));
                    default: ;
                endcase
                lat = (s2 == 32'd0) ? 1 : 33;
            end else begin
                dop = 3'b000;
                aop = 12'd1 << $urandom_range(0, 11);
                lat = 0;
            end
            runInstr($sformatf("rand%0d op%h/%h", n, dop, aop),
                     mkBus(dop, aop, 1'b0, 1'b0, 5'($urandom), s1, s2, 32'd0, 32'($urandom)),
                     lat, refModel(dop, aop, s1, s2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
